// File: rtl/rgb_frame_check_seq.sv
// Frame sequencer for the D5M RGB pixel checker: arms on start, gates whole frames
// into the checker and flags line/frame geometry errors. Optional frame_sum via RGB_SEQ_CRC_EN.
module rgb_frame_check_seq #(
  parameter int IMG_WIDTH   = 640,
  parameter int IMG_HEIGHT  = 480,
  parameter int DATA_WIDTH  = 8,
  parameter int FRM_CNT_W   = 8,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [FRM_CNT_W-1:0]  num_frames,
  input  logic                  fval,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] iRed,
  input  logic [DATA_WIDTH-1:0] iGreen,
  input  logic [DATA_WIDTH-1:0] iBlue,
  output logic                  chk_valid,
  output logic [DATA_WIDTH-1:0] chk_red,
  output logic [DATA_WIDTH-1:0] chk_green,
  output logic [DATA_WIDTH-1:0] chk_blue,
  output logic [15:0]           x_cnt,
  output logic [15:0]           y_cnt,
  output logic [FRM_CNT_W-1:0]  frame_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  size_err,
  output logic                  timeout_err
`ifdef RGB_SEQ_CRC_EN
  ,
  output logic [31:0]           frame_sum
`endif
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SOF, S_CAPTURE, S_CHECK, S_DONE
  } state_e;

  state_e                 state_q;
  logic                   fval_q, valid_q;
  logic                   chk_valid_q, busy_q, done_q, size_err_q, timeout_err_q;
  logic [DATA_WIDTH-1:0]  red_q, green_q, blue_q;
  logic [15:0]            x_cnt_q, y_cnt_q;
  logic [FRM_CNT_W-1:0]   frame_cnt_q, num_q;
  logic [TMO_W-1:0]       tmo_q;

  logic fval_rise, fval_fall, pix_acc, line_end, tmo_hit;
  logic [FRM_CNT_W-1:0] frm_inc;

  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;
  // The fval-rise cycle itself is part of the frame, so a pixel there is captured too.
  assign pix_acc   = fval & valid &
                     ((state_q == S_CAPTURE) | ((state_q == S_WAIT_SOF) & fval_rise));
  // A line still open when fval drops is closed in the same cycle.
  assign line_end  = (state_q == S_CAPTURE) & valid_q & (~valid | ~fval);
  assign tmo_hit   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
  assign frm_inc   = frame_cnt_q + FRM_CNT_W'(1);

`ifdef RGB_SEQ_CRC_EN
  logic [31:0] acc_q, sum_q;
  logic [31:0] pix_val;
  assign pix_val = 32'({iRed, iGreen, iBlue});

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      sum_q <= '0;
    end else if (!abort) begin
      case (state_q)
        S_WAIT_SOF: acc_q <= pix_acc ? pix_val : 32'd0;
        S_CAPTURE:  if (pix_acc) acc_q <= acc_q + pix_val;
        S_CHECK:    sum_q <= acc_q;
        default:    ;
      endcase
    end
  end

  assign frame_sum = sum_q;
`endif

  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fval_q        <= 1'b0;
      valid_q       <= 1'b0;
      chk_valid_q   <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      x_cnt_q       <= '0;
      y_cnt_q       <= '0;
      frame_cnt_q   <= '0;
      num_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      size_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      tmo_q         <= '0;
    end else begin
      fval_q      <= fval;
      valid_q     <= valid;
      done_q      <= 1'b0;
      chk_valid_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
        busy_q  <= 1'b0;
      end else begin
        if (pix_acc) begin
          chk_valid_q <= 1'b1;
          red_q       <= iRed;
          green_q     <= iGreen;
          blue_q      <= iBlue;
          if (x_cnt_q != 16'hFFFF) x_cnt_q <= x_cnt_q + 16'd1;
        end
        if (line_end) begin
          if (x_cnt_q != 16'(IMG_WIDTH)) size_err_q <= 1'b1;
          x_cnt_q <= '0;
          if (y_cnt_q != 16'hFFFF) y_cnt_q <= y_cnt_q + 16'd1;
        end
        case (state_q)
          S_IDLE: begin
            tmo_q <= '0;
            if (start) begin
              if (num_frames != '0) begin
                num_q         <= num_frames;
                frame_cnt_q   <= '0;
                x_cnt_q       <= '0;
                y_cnt_q       <= '0;
                size_err_q    <= 1'b0;
                timeout_err_q <= 1'b0;
                busy_q        <= 1'b1;
                state_q       <= S_WAIT_SOF;
              end else begin
                state_q <= S_DONE;
              end
            end
          end
          S_WAIT_SOF: begin
            if (fval_rise) begin
              tmo_q   <= '0;
              state_q <= S_CAPTURE;
            end else if (fval_fall) begin
              tmo_q <= '0;
            end else if (tmo_hit) begin
              timeout_err_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_DONE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_CAPTURE: begin
            if (fval_fall) begin
              tmo_q   <= '0;
              state_q <= S_CHECK;
            end else if (tmo_hit) begin
              timeout_err_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= S_DONE;
            end else begin
              tmo_q <= tmo_q + TMO_W'(1);
            end
          end
          S_CHECK: begin
            tmo_q       <= '0;
            frame_cnt_q <= frm_inc;
            if (y_cnt_q != 16'(IMG_HEIGHT)) size_err_q <= 1'b1;
            if (frm_inc == num_q) begin
              busy_q  <= 1'b0;
              state_q <= S_DONE;
            end else begin
              x_cnt_q <= '0;
              y_cnt_q <= '0;
              state_q <= S_WAIT_SOF;
            end
          end
          S_DONE: begin
            tmo_q   <= '0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign chk_valid   = chk_valid_q;
  assign chk_red     = red_q;
  assign chk_green   = green_q;
  assign chk_blue    = blue_q;
  assign x_cnt       = x_cnt_q;
  assign y_cnt       = y_cnt_q;
  assign frame_cnt   = frame_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign size_err    = size_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_rgb_frame_check_seq.sv
// Directed bench for rgb_frame_check_seq on a small 4x110 geometry with a 1000-cycle timeout.
module tb_rgb_frame_check_seq;
  localparam int W = 4, H = 110, DW = 8, FW = 8, TMO = 1000;

  logic          pixclk = 1'b0;
  logic          reset, start, abort, fval, valid;
  logic [FW-1:0] num_frames;
  logic [DW-1:0] iRed, iGreen, iBlue;
  logic          chk_valid, busy, done, size_err, timeout_err;
  logic [DW-1:0] chk_red, chk_green, chk_blue;
  logic [15:0]   x_cnt, y_cnt;
  logic [FW-1:0] frame_cnt;
`ifdef RGB_SEQ_CRC_EN
  logic [31:0]   frame_sum;
`endif

  rgb_frame_check_seq #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .DATA_WIDTH(DW), .FRM_CNT_W(FW), .TIMEOUT_CYC(TMO)
  ) dut (
    .pixclk(pixclk), .reset(reset), .start(start), .abort(abort),
    .num_frames(num_frames), .fval(fval), .valid(valid),
    .iRed(iRed), .iGreen(iGreen), .iBlue(iBlue),
    .chk_valid(chk_valid), .chk_red(chk_red), .chk_green(chk_green), .chk_blue(chk_blue),
    .x_cnt(x_cnt), .y_cnt(y_cnt), .frame_cnt(frame_cnt),
    .busy(busy), .done(done), .size_err(size_err), .timeout_err(timeout_err)
`ifdef RGB_SEQ_CRC_EN
    , .frame_sum(frame_sum)
`endif
  );

  always #5 pixclk = ~pixclk;

  int          checks = 0, failures = 0;
  int          pix_seen = 0;
  logic [31:0] sum_seen = 0, exp_sum = 0, exp_cat = 0;

  always @(negedge pixclk) begin
    if (chk_valid === 1'b1) begin
      pix_seen = pix_seen + 1;
      sum_seen = sum_seen + 32'(chk_red) + 32'(chk_green) + 32'(chk_blue);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  task automatic clr_score();
    pix_seen = 0; sum_seen = 0; exp_sum = 0; exp_cat = 0;
  endtask

  task automatic send_line(input int n, input int l, input bit cap, input bit chk_first);
    for (int p = 0; p < n; p++) begin
      valid = 1'b1;
      iRed = 8'(l * 7 + p); iGreen = 8'(p * 3 + 1); iBlue = 8'(l ^ p);
      if (cap) begin
        exp_sum = exp_sum + 32'(iRed) + 32'(iGreen) + 32'(iBlue);
        exp_cat = exp_cat + 32'({iRed, iGreen, iBlue});
      end
      step();
      if (chk_first && p == 0) begin
        chk("first_pix_valid", 32'(chk_valid), 32'(cap));
        if (cap) chk("first_pix_red", 32'(chk_red), 32'(iRed));
      end
    end
    valid = 1'b0;
    step(); step();
  endtask

  task automatic send_frame(input int lines, input int short_l, input bit cap, input bit pre);
    if (!pre) begin fval = 1'b1; step(); end
    for (int l = 0; l < lines; l++) send_line((l == short_l) ? W - 1 : W, l, cap, l == 0);
    fval = 1'b0;
    step();
  endtask

  initial begin
    int dseen;
    reset = 1'b1; start = 1'b0; abort = 1'b0; num_frames = '0;
    fval = 1'b0; valid = 1'b0; iRed = '0; iGreen = '0; iBlue = '0;
    step(); step();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_chk_valid", 32'(chk_valid), 0);
    chk("rst_frame_cnt", 32'(frame_cnt), 0);
    chk("rst_flags", 32'({size_err, timeout_err}), 0);
    reset = 1'b0;
    step();

    // two exact frames
    clr_score();
    num_frames = 2; start = 1'b1; step(); start = 1'b0;
    chk("t1_busy", 32'(busy), 1);
    send_frame(H, -1, 1, 0);
    step();
    chk("t1_fc1", 32'(frame_cnt), 1);
    chk("t1_busy_mid", 32'(busy), 1);
`ifdef RGB_SEQ_CRC_EN
    chk("t1_frame_sum", frame_sum, exp_cat);
`endif
    step(); step();
    send_frame(H, -1, 1, 0);
    step();
    chk("t1_busy_done_state", 32'(busy), 0);
    chk("t1_done_early", 32'(done), 0);
    step();
    chk("t1_done", 32'(done), 1);
    chk("t1_fc2", 32'(frame_cnt), 2);
    chk("t1_size_err", 32'(size_err), 0);
    chk("t1_timeout_err", 32'(timeout_err), 0);
    chk("t1_y_cnt", 32'(y_cnt), H);
    chk("t1_pix_cnt", 32'(pix_seen), 2 * W * H);
    chk("t1_pix_sum", sum_seen, exp_sum);
    step();
    chk("t1_done_pulse", 32'(done), 0);

    // armed while a frame is already running
    clr_score();
    fval = 1'b1; step(); step();
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    chk("t2_busy", 32'(busy), 1);
    send_frame(3, -1, 0, 1);
    step(); step();
    chk("t2_skipped", 32'(pix_seen), 0);
    chk("t2_fc0", 32'(frame_cnt), 0);
    send_frame(H, -1, 1, 0);
    step(); step();
    chk("t2_done", 32'(done), 1);
    chk("t2_fc1", 32'(frame_cnt), 1);
    chk("t2_pix_cnt", 32'(pix_seen), W * H);
    chk("t2_pix_sum", sum_seen, exp_sum);

    // short line then short frame
    num_frames = 2; start = 1'b1; step(); start = 1'b0;
    send_frame(H, 5, 1, 0);
    step();
    chk("t3_size_err_line", 32'(size_err), 1);
    chk("t3_busy", 32'(busy), 1);
    step(); step();
    send_frame(H - 1, -1, 1, 0);
    step(); step();
    chk("t3_done", 32'(done), 1);
    chk("t3_fc2", 32'(frame_cnt), 2);
    step(); step();
    chk("t3_size_err_sticky", 32'(size_err), 1);

    // timeout with fval held low
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    chk("t4_size_err_clr", 32'(size_err), 0);
    repeat (TMO - 1) step();
    chk("t4_no_timeout_yet", 32'(timeout_err), 0);
    chk("t4_busy_before", 32'(busy), 1);
    step();
    chk("t4_timeout", 32'(timeout_err), 1);
    chk("t4_busy_after", 32'(busy), 0);
    step();
    chk("t4_done", 32'(done), 1);
    step();
    chk("t4_timeout_sticky", 32'(timeout_err), 1);

    // abort during capture at line 100
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    chk("t5_timeout_clr", 32'(timeout_err), 0);
    fval = 1'b1; step();
    send_line(W - 1, 0, 1, 0);
    for (int l = 1; l < 100; l++) send_line(W, l, 1, 0);
    chk("t5_size_err", 32'(size_err), 1);
    valid = 1'b1; step(); step();
    chk("t5_chk_valid_pre", 32'(chk_valid), 1);
    abort = 1'b1; step(); abort = 1'b0;
    valid = 1'b0; fval = 1'b0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_chk_valid", 32'(chk_valid), 0);
    chk("t5_y_hold", 32'(y_cnt), 100);
    chk("t5_x_hold", 32'(x_cnt), 2);
    chk("t5_size_err_hold", 32'(size_err), 1);
    dseen = int'(done);
    repeat (4) begin step(); if (done) dseen++; end
    chk("t5_no_done", 32'(dseen), 0);
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    chk("t5_restart_flags", 32'({size_err, timeout_err}), 0);
    chk("t5_restart_xy", 32'({x_cnt, y_cnt}), 0);
    chk("t5_restart_busy", 32'(busy), 1);
    abort = 1'b1; step(); abort = 1'b0;
    chk("t5_abort_wait", 32'(busy), 0);

    // zero-frame request, start while busy, valid without fval
    num_frames = 0; start = 1'b1; step(); start = 1'b0;
    chk("t6_busy0", 32'(busy), 0);
    chk("t6_done_early", 32'(done), 0);
    step();
    chk("t6_done", 32'(done), 1);
    chk("t6_busy_never", 32'(busy), 0);
    step();
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    chk("t6_busy1", 32'(busy), 1);
    num_frames = 5; start = 1'b1; step(); start = 1'b0;
    clr_score();
    valid = 1'b1; iRed = 8'h55; repeat (3) step(); valid = 1'b0;
    step();
    chk("t6_valid_no_fval", 32'(pix_seen), 0);
    send_frame(H, -1, 1, 0);
    step(); step();
    chk("t6_done_one_frame", 32'(done), 1);
    chk("t6_fc1", 32'(frame_cnt), 1);

    // reset in the middle of a frame
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    fval = 1'b1; step();
    send_line(W, 0, 1, 0);
    valid = 1'b1; step();
    reset = 1'b1; step();
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_xy", 32'({x_cnt, y_cnt}), 0);
    chk("rst_mid_fc", 32'(frame_cnt), 0);
    chk("rst_mid_chk_valid", 32'(chk_valid), 0);
    reset = 1'b0; valid = 1'b0; step();
    num_frames = 1; start = 1'b1; step(); start = 1'b0;
    clr_score();
    send_frame(2, -1, 0, 1);
    step(); step();
    chk("rst_mid_skip", 32'(pix_seen), 0);
    chk("rst_mid_wait", 32'(busy), 1);
    abort = 1'b1; step(); abort = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
